// File: rtl/ramb_s2_s4_fifo_ctrl.sv
// FIFO controller for a 2048x2 (write) / 1024x4 (read) dual-port block RAM.
// Optional sticky OVERFLOW/UNDERFLOW flags are enabled by defining RAMB_FIFO_ERR_FLAGS_EN.
module ramb_s2_s4_fifo_ctrl #(
  parameter logic [11:0] AFULL_THRESH  = 12'd1984,
  parameter logic [11:0] AEMPTY_THRESH = 12'd4
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        WR_EN,
  input  logic [1:0]  DIN,
  input  logic        RD_EN,
  output logic [3:0]  DOUT,
  output logic        DOUT_VALID,
  output logic        FULL,
  output logic        EMPTY,
  output logic        PROG_FULL,
  output logic        PROG_EMPTY,
  output logic [11:0] LEVEL,
  output logic [10:0] ADDRA,
  output logic [1:0]  DIA,
  output logic        ENA,
  output logic        WEA,
  output logic [9:0]  ADDRB,
  output logic        ENB,
  output logic        WEB,
  input  logic [3:0]  DOB_RAM
`ifdef RAMB_FIFO_ERR_FLAGS_EN
  ,
  input  logic        ERR_CLR,
  output logic        OVERFLOW,
  output logic        UNDERFLOW
`endif
);

  logic [10:0] wr_ptr;
  logic [9:0]  rd_ptr;
  logic        wr_acc;
  logic        rd_acc;
  logic [12:0] level_next;
  logic        rd_vld_p0;

  assign wr_acc = WR_EN & ~FULL;
  assign rd_acc = RD_EN & ~EMPTY;

  assign ENA   = wr_acc;
  assign WEA   = wr_acc;
  assign ADDRA = wr_ptr;
  assign DIA   = DIN;
  assign ENB   = rd_acc;
  assign ADDRB = rd_ptr;
  assign WEB   = 1'b0;

  // A read is only accepted with LEVEL >= 2, so the subtraction cannot go negative.
  assign level_next = {1'b0, LEVEL} + {12'd0, wr_acc} - {11'd0, rd_acc, 1'b0};

  // Pointers, level and flags (flags registered from level_next)
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      LEVEL      <= '0;
      FULL       <= 1'b0;
      EMPTY      <= 1'b1;
      PROG_FULL  <= 1'b0;
      PROG_EMPTY <= 1'b1;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 11'd1;
      if (rd_acc) rd_ptr <= rd_ptr + 10'd1;
      LEVEL      <= level_next[11:0];
      FULL       <= (level_next == 13'd2048);
      EMPTY      <= (level_next < 13'd2);
      PROG_FULL  <= (level_next >= {1'b0, AFULL_THRESH});
      PROG_EMPTY <= (level_next <= {1'b0, AEMPTY_THRESH});
    end
  end

  // Stage p0: RAM registers DOB; stage p1: controller captures it into DOUT
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rd_vld_p0  <= 1'b0;
      DOUT_VALID <= 1'b0;
      DOUT       <= '0;
    end else begin
      rd_vld_p0  <= rd_acc;
      DOUT_VALID <= rd_vld_p0;
      if (rd_vld_p0) DOUT <= DOB_RAM;
    end
  end

`ifdef RAMB_FIFO_ERR_FLAGS_EN
  // Set wins over a simultaneous clear.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      OVERFLOW  <= 1'b0;
      UNDERFLOW <= 1'b0;
    end else begin
      OVERFLOW  <= (WR_EN & FULL)  | (OVERFLOW  & ~ERR_CLR);
      UNDERFLOW <= (RD_EN & EMPTY) | (UNDERFLOW & ~ERR_CLR);
    end
  end
`endif

endmodule

// File: tb/tb_ramb_s2_s4_fifo_ctrl.sv
// Directed bench for ramb_s2_s4_fifo_ctrl with a behavioural 2048x2 / 1024x4 RAM.
module tb_ramb_s2_s4_fifo_ctrl;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        WR_EN = 1'b0;
  logic [1:0]  DIN = 2'b00;
  logic        RD_EN = 1'b0;
  logic [3:0]  DOUT;
  logic        DOUT_VALID;
  logic        FULL, EMPTY, PROG_FULL, PROG_EMPTY;
  logic [11:0] LEVEL;
  logic [10:0] ADDRA;
  logic [1:0]  DIA;
  logic        ENA, WEA;
  logic [9:0]  ADDRB;
  logic        ENB, WEB;
  logic [3:0]  DOB_RAM = 4'd0;
`ifdef RAMB_FIFO_ERR_FLAGS_EN
  logic        ERR_CLR = 1'b0;
  logic        OVERFLOW, UNDERFLOW;
`endif

  ramb_s2_s4_fifo_ctrl dut (
    .CLK(CLK), .RST_N(RST_N), .WR_EN(WR_EN), .DIN(DIN), .RD_EN(RD_EN),
    .DOUT(DOUT), .DOUT_VALID(DOUT_VALID), .FULL(FULL), .EMPTY(EMPTY),
    .PROG_FULL(PROG_FULL), .PROG_EMPTY(PROG_EMPTY), .LEVEL(LEVEL),
    .ADDRA(ADDRA), .DIA(DIA), .ENA(ENA), .WEA(WEA),
    .ADDRB(ADDRB), .ENB(ENB), .WEB(WEB), .DOB_RAM(DOB_RAM)
`ifdef RAMB_FIFO_ERR_FLAGS_EN
    , .ERR_CLR(ERR_CLR), .OVERFLOW(OVERFLOW), .UNDERFLOW(UNDERFLOW)
`endif
  );

  always #5 CLK = ~CLK;

  // Block RAM: 2-bit write port, 4-bit registered read port, low symbol at even address.
  logic [1:0] mem [0:2047];
  always @(posedge CLK) begin
    if (ENA && WEA) mem[ADDRA] <= DIA;
    if (ENB) DOB_RAM <= {mem[{ADDRB, 1'b1}], mem[{ADDRB, 1'b0}]};
  end

  int vectors = 0;
  int miscompares = 0;

  // Reference state
  int         lvl = 0;
  int         wptr = 0;
  int         rptr = 0;
  logic [1:0] symq [$];
  logic       pend = 1'b0;
  logic [3:0] pend_word = 4'd0;
  logic [3:0] exp_dout = 4'd0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic step(input logic wr, input logic [1:0] din, input logic rd);
    logic       wacc, racc;
    logic [3:0] word;
    logic       exp_vld;
    wacc = wr && (lvl != 2048);
    racc = rd && (lvl >= 2);
    word = 4'd0;
    WR_EN = wr; DIN = din; RD_EN = rd;
    #1;
    chk("wea", WEA, wacc);
    chk("ena", ENA, wacc);
    chk("enb", ENB, racc);
    chk("web", WEB, 1'b0);
    if (wacc) begin
      chk("addra", ADDRA, wptr);
      chk("dia", DIA, din);
    end
    if (racc) chk("addrb", ADDRB, rptr);
    if (racc) begin
      word = {symq[1], symq[0]};
      void'(symq.pop_front());
      void'(symq.pop_front());
      rptr = (rptr + 1) % 1024;
      lvl = lvl - 2;
    end
    if (wacc) begin
      symq.push_back(din);
      wptr = (wptr + 1) % 2048;
      lvl = lvl + 1;
    end
    cyc();
    exp_vld = pend;
    if (pend) exp_dout = pend_word;
    pend = racc;
    pend_word = word;
    chk("dout_valid", DOUT_VALID, exp_vld);
    chk("dout", DOUT, exp_dout);
    chk("level", LEVEL, lvl);
    chk("empty", EMPTY, lvl < 2);
    chk("full", FULL, lvl == 2048);
    chk("prog_full", PROG_FULL, lvl >= 1984);
    chk("prog_empty", PROG_EMPTY, lvl <= 4);
    WR_EN = 1'b0; RD_EN = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_level"}, LEVEL, 12'd0);
    chk({tag, "_empty"}, EMPTY, 1'b1);
    chk({tag, "_pempty"}, PROG_EMPTY, 1'b1);
    chk({tag, "_full"}, FULL, 1'b0);
    chk({tag, "_pfull"}, PROG_FULL, 1'b0);
    chk({tag, "_dout"}, DOUT, 4'd0);
    chk({tag, "_dvalid"}, DOUT_VALID, 1'b0);
  endtask

  task automatic model_reset();
    lvl = 0; wptr = 0; rptr = 0;
    symq.delete();
    pend = 1'b0; pend_word = 4'd0; exp_dout = 4'd0;
  endtask

  initial begin
    // Power-on reset
    @(negedge CLK);
    @(negedge CLK);
    #1;
    chk_reset_outputs("rst0");
`ifdef RAMB_FIFO_ERR_FLAGS_EN
    chk("rst0_ovf", OVERFLOW, 1'b0);
    chk("rst0_udf", UNDERFLOW, 1'b0);
`endif
    @(negedge CLK);
    RST_N = 1'b1;

    // Two symbols pack into one word, first symbol in the low bits
    step(1'b1, 2'b01, 1'b0);
    chk("t1_lvl1", LEVEL, 12'd1);
    chk("t1_empty1", EMPTY, 1'b1);
    step(1'b1, 2'b10, 1'b0);
    chk("t1_lvl2", LEVEL, 12'd2);
    chk("t1_empty2", EMPTY, 1'b0);
    step(1'b0, 2'b00, 1'b1);
    chk("t1_lvl0", LEVEL, 12'd0);
    chk("t1_novalid_n", DOUT_VALID, 1'b0);
    step(1'b0, 2'b00, 1'b0);
    chk("t1_valid", DOUT_VALID, 1'b1);
    chk("t1_dout", DOUT, 4'b1001);
    step(1'b0, 2'b00, 1'b0);
    chk("t1_valid_drop", DOUT_VALID, 1'b0);
    chk("t1_dout_hold", DOUT, 4'b1001);

    // Half word is not readable
    step(1'b1, 2'b11, 1'b0);
    step(1'b0, 2'b00, 1'b1);
    chk("t2_lvl", LEVEL, 12'd1);
    chk("t2_empty", EMPTY, 1'b1);
`ifdef RAMB_FIFO_ERR_FLAGS_EN
    chk("t2_udf", UNDERFLOW, 1'b1);
    ERR_CLR = 1'b1;
    step(1'b0, 2'b00, 1'b0);
    ERR_CLR = 1'b0;
    chk("t2_udf_clr", UNDERFLOW, 1'b0);
`endif
    step(1'b0, 2'b00, 1'b0);
    chk("t2_novalid", DOUT_VALID, 1'b0);

    // Fill to 2048 symbols
    for (int i = 0; i < 2047; i++) step(1'b1, i[1:0], 1'b0);
    chk("t3_full", FULL, 1'b1);
    chk("t3_pfull", PROG_FULL, 1'b1);
    chk("t3_lvl", LEVEL, 12'd2048);
    step(1'b1, 2'b10, 1'b0);
    chk("t3_lvl_hold", LEVEL, 12'd2048);
`ifdef RAMB_FIFO_ERR_FLAGS_EN
    chk("t3_ovf", OVERFLOW, 1'b1);
    step(1'b0, 2'b00, 1'b0);
    chk("t3_ovf_sticky", OVERFLOW, 1'b1);
    ERR_CLR = 1'b1;
    step(1'b0, 2'b00, 1'b0);
    ERR_CLR = 1'b0;
    chk("t3_ovf_clr", OVERFLOW, 1'b0);
`endif

    // Full with write and read together: read only
    step(1'b1, 2'b11, 1'b1);
    chk("t4_lvl", LEVEL, 12'd2046);
    chk("t4_full", FULL, 1'b0);
    while (lvl > 2) step(1'b0, 2'b00, 1'b1);
    step(1'b1, 2'b01, 1'b1);
    chk("t4_lvl1", LEVEL, 12'd1);
    chk("t4_empty", EMPTY, 1'b1);
    step(1'b0, 2'b00, 1'b0);
    step(1'b0, 2'b00, 1'b0);

    // Long concurrent stream wrapping both pointers
    for (int i = 0; i < 3000; i++) step(1'b1, i[1:0] ^ i[3:2], 1'b1);
    while (lvl >= 2) step(1'b0, 2'b00, 1'b1);
    step(1'b0, 2'b00, 1'b0);
    step(1'b0, 2'b00, 1'b0);

    // Reset with a read in flight
    step(1'b1, 2'b01, 1'b0);
    step(1'b1, 2'b10, 1'b0);
    step(1'b0, 2'b00, 1'b1);
    RST_N = 1'b0;
    #1;
    chk_reset_outputs("rst1");
    model_reset();
    cyc();
    chk("rst1_dvalid_a", DOUT_VALID, 1'b0);
    cyc();
    chk("rst1_dvalid_b", DOUT_VALID, 1'b0);
    RST_N = 1'b1;
    step(1'b0, 2'b00, 1'b0);
    step(1'b1, 2'b01, 1'b0);
    step(1'b1, 2'b11, 1'b0);
    step(1'b0, 2'b00, 1'b1);
    step(1'b0, 2'b00, 1'b0);
    chk("t6_valid", DOUT_VALID, 1'b1);
    chk("t6_dout", DOUT, 4'b1101);
    step(1'b0, 2'b00, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
